// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM -> WB retire bus (handshake, instruction payload, late load data).
//  master (MEM side) drives in_valid, in_rd, in_wb_sel, in_funct3, in_alu, in_pc4, in_imm, ld_valid, ld_data
//                    and receives in_ready.
//  slave  (WB side)  receives the payload and drives in_ready (combinational).
interface wb_stage_if;
   localparam int unsigned XLEN = 32;

   logic            in_valid;
   logic            in_ready;
   logic [4:0]      in_rd;
   logic [1:0]      in_wb_sel;
   logic [2:0]      in_funct3;
   logic [XLEN-1:0] in_alu;
   logic [XLEN-1:0] in_pc4;
   logic [XLEN-1:0] in_imm;
   logic            ld_valid;
   logic [XLEN-1:0] ld_data;

   modport master (
      output in_valid, in_rd, in_wb_sel, in_funct3, in_alu, in_pc4, in_imm, ld_valid, ld_data,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_rd, in_wb_sel, in_funct3, in_alu, in_pc4, in_imm, ld_valid, ld_data,
      output in_ready
   );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: RV32I writeback stage driving the register file write port.
//  Accepts retiring instructions over mem (wb_stage_if.slave), waits for late load data,
//  selects/extracts the writeback value, counts retired instructions and optionally
//  forwards the in-flight write to the register file read ports.
// Ports:
//  clk, rst_n          clock (rising edge), asynchronous active-low reset
//  flush               synchronous kill of the held instruction
//  mem                 retire bus from MEM (valid/ready, payload, ld_valid/ld_data)
//  WrEn/WrAdr/WrData   register file write port
//  RdAdr1/2, RfRead1/2 register file read addresses and raw read data
//  Read1/2             read data after optional write forwarding (comb)
//  retire_cnt          count of committed instructions (wraps)
// Configuration macro: WB_BYPASS_EN enables same-cycle write->read forwarding.
module wb_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   wb_stage_if.slave        mem,
   output logic             WrEn,
   output logic [4:0]       WrAdr,
   output logic [XLEN-1:0]  WrData,
   input  logic [4:0]       RdAdr1,
   input  logic [4:0]       RdAdr2,
   input  logic [XLEN-1:0]  RfRead1,
   input  logic [XLEN-1:0]  RfRead2,
   output logic [XLEN-1:0]  Read1,
   output logic [XLEN-1:0]  Read2,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_PC4  = 2'b10;
   localparam logic [1:0] SEL_IMM  = 2'b11;

   typedef enum logic [1:0] {
      EMPTY   = 2'b00,
      WAIT_LD = 2'b01,
      FULL    = 2'b10
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      f3_q;
   logic [1:0]      off_q;
   logic            ready_c;
   logic            accept_c;
   logic            is_load_c;
   logic            ld_take_c;
   logic            count_c;
   logic [XLEN-1:0] sel_c;

   // Load extraction: byte/half picked by the latched offset, then sign/zero extended.
   function automatic logic [XLEN-1:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [XLEN-1:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  extract = {{(XLEN-8){b[7]}}, b};
         3'b001:  extract = {{(XLEN-16){h[15]}}, h};
         3'b100:  extract = {{(XLEN-8){1'b0}}, b};
         3'b101:  extract = {{(XLEN-16){1'b0}}, h};
         default: extract = w;
      endcase
   endfunction

   assign ready_c      = !flush && (state_q != WAIT_LD);
   assign mem.in_ready = ready_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Next state and datapath strobes
   always_comb begin
      state_d   = state_q;
      accept_c  = mem.in_valid && ready_c;
      is_load_c = (mem.in_wb_sel == SEL_LOAD);
      ld_take_c = 1'b0;
      count_c   = 1'b0;
      sel_c     = mem.in_alu;

      case (mem.in_wb_sel)
         SEL_PC4: sel_c = mem.in_pc4;
         SEL_IMM: sel_c = mem.in_imm;
         default: sel_c = mem.in_alu;
      endcase

      case (state_q)
         EMPTY, FULL: begin
            count_c = (state_q == FULL) && !flush;
            if (accept_c) state_d = is_load_c ? WAIT_LD : FULL;
            else          state_d = EMPTY;
         end
         WAIT_LD: begin
            ld_take_c = mem.ld_valid && !flush;
            if (mem.ld_valid) state_d = FULL;
         end
         default: state_d = EMPTY;
      endcase

      if (flush) state_d = EMPTY;
   end

   // Write port payload and load context; WrAdr is captured at accept for loads too,
   // which is harmless because WrEn only looks at it in FULL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         WrAdr  <= 5'd0;
         WrData <= '0;
         f3_q   <= 3'd0;
         off_q  <= 2'd0;
      end else if (accept_c) begin
         WrAdr <= mem.in_rd;
         if (is_load_c) begin
            f3_q  <= mem.in_funct3;
            off_q <= mem.in_alu[1:0];
         end else begin
            WrData <= sel_c;
         end
      end else if (ld_take_c) begin
         WrData <= extract(f3_q, off_q, mem.ld_data);
      end
   end

   // Retired-instruction counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       retire_cnt <= '0;
      else if (count_c) retire_cnt <= retire_cnt + CNT_W'(1);
   end

   // A flush in FULL must stop the register file write in the same cycle.
   assign WrEn = (state_q == FULL) && (WrAdr != 5'd0) && !flush;

`ifdef WB_BYPASS_EN
   // WrEn already excludes flush and x0.
   assign Read1 = (WrEn && (WrAdr == RdAdr1)) ? WrData : RfRead1;
   assign Read2 = (WrEn && (WrAdr == RdAdr2)) ? WrData : RfRead2;
`else
   logic unused_rdadr_c;
   assign unused_rdadr_c = ^{RdAdr1, RdAdr2};
   assign Read1 = RfRead1;
   assign Read2 = RfRead2;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed bench for wb_stage with an instruction-level reference model.
module tb_wb_stage;
   localparam int unsigned CW = 4;
   localparam int H_NONE  = 0;
   localparam int H_AWAIT = 1;
   localparam int H_RES   = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          WrEn;
   logic [4:0]    WrAdr;
   logic [31:0]   WrData;
   logic [4:0]    RdAdr1, RdAdr2;
   logic [31:0]   RfRead1, RfRead2;
   logic [31:0]   Read1, Read2;
   logic [CW-1:0] retire_cnt;

   wb_stage_if bus ();

   wb_stage #(.XLEN(32), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .mem        (bus.slave),
      .WrEn       (WrEn),
      .WrAdr      (WrAdr),
      .WrData     (WrData),
      .RdAdr1     (RdAdr1),
      .RdAdr2     (RdAdr2),
      .RfRead1    (RfRead1),
      .RfRead2    (RfRead2),
      .Read1      (Read1),
      .Read2      (Read2),
      .retire_cnt (retire_cnt)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: what the instruction held by the stage is and what it will write.
   int            m_hold;
   logic [4:0]    m_rd;
   logic [31:0]   m_data;
   logic [2:0]    m_f3;
   logic [1:0]    m_off;
   logic [CW-1:0] m_cnt;

   function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
      logic [31:0] v;
      int          sh;
      case (f3)
         3'd0, 3'd4: begin
            sh = 8 * int'(off);
            v  = (w >> sh) & 32'h0000_00FF;
            if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
         end
         3'd1, 3'd5: begin
            sh = 16 * (int'(off) / 2);
            v  = (w >> sh) & 32'h0000_FFFF;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hold <= H_NONE;
         m_rd   <= 5'd0;
         m_data <= 32'd0;
         m_f3   <= 3'd0;
         m_off  <= 2'd0;
         m_cnt  <= '0;
      end else begin
         if (m_hold == H_RES && !flush) m_cnt <= m_cnt + 1'b1;
         if (flush) begin
            m_hold <= H_NONE;
         end else if (m_hold == H_AWAIT) begin
            if (bus.ld_valid) begin
               m_hold <= H_RES;
               m_data <= ld_model(m_f3, m_off, bus.ld_data);
            end
         end else if (bus.in_valid) begin
            m_rd <= bus.in_rd;
            case (bus.in_wb_sel)
               2'd1: begin
                  m_hold <= H_AWAIT;
                  m_f3   <= bus.in_funct3;
                  m_off  <= bus.in_alu[1:0];
               end
               2'd2:    begin m_hold <= H_RES; m_data <= bus.in_pc4; end
               2'd3:    begin m_hold <= H_RES; m_data <= bus.in_imm; end
               default: begin m_hold <= H_RES; m_data <= bus.in_alu; end
            endcase
         end else begin
            m_hold <= H_NONE;
         end
      end
   end

   // Per-cycle comparison against the model.
   logic        e_wr;
   logic [31:0] e_r1, e_r2;
   always @(negedge clk) begin
      e_wr = (m_hold == H_RES) && (m_rd != 5'd0) && !flush;
      e_r1 = RfRead1;
      e_r2 = RfRead2;
`ifdef WB_BYPASS_EN
      if (e_wr && m_rd == RdAdr1) e_r1 = m_data;
      if (e_wr && m_rd == RdAdr2) e_r2 = m_data;
`endif
      chk("m_in_ready", 32'(bus.in_ready), 32'(!flush && m_hold != H_AWAIT));
      chk("m_WrEn", 32'(WrEn), 32'(e_wr));
      chk("m_retire_cnt", 32'(retire_cnt), 32'(m_cnt));
      chk("m_Read1", Read1, e_r1);
      chk("m_Read2", Read2, e_r2);
      if (m_hold == H_RES) begin
         chk("m_WrAdr", 32'(WrAdr), 32'(m_rd));
         chk("m_WrData", WrData, m_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.ld_valid  = 1'b0;
      bus.in_wb_sel = 2'd0;
      bus.in_funct3 = 3'd0;
      bus.in_rd     = 5'd0;
   endtask

   task automatic put(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                      input logic [31:0] alu);
      bus.in_valid  = 1'b1;
      bus.in_rd     = rd;
      bus.in_wb_sel = sel;
      bus.in_funct3 = f3;
      bus.in_alu    = alu;
   endtask

   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] data;
      logic [31:0] exp;
   } ld_vec_t;

   ld_vec_t lv[10] = '{
      '{3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80},
      '{3'b101, 2'd2, 32'h80FF_0000, 32'h0000_80FF},
      '{3'b001, 2'd2, 32'h80FF_0000, 32'hFFFF_80FF},
      '{3'b001, 2'd3, 32'h80FF_0000, 32'hFFFF_80FF},
      '{3'b100, 2'd2, 32'h80FF_0000, 32'h0000_00FF},
      '{3'b010, 2'd1, 32'h1234_5678, 32'h1234_5678},
      '{3'b011, 2'd0, 32'hCAFE_BABE, 32'hCAFE_BABE},
      '{3'b000, 2'd1, 32'h0000_8500, 32'hFFFF_FF85},
      '{3'b100, 2'd0, 32'h1234_5680, 32'h0000_0080},
      '{3'b001, 2'd0, 32'h0000_F00F, 32'hFFFF_F00F}
   };

   logic [CW-1:0] cnt0;
   logic [31:0]   exp_r1;

   initial begin
      rst_n = 1'b0; flush = 1'b0;
      bus.in_valid = 1'b0; bus.in_rd = 5'd0; bus.in_wb_sel = 2'd0; bus.in_funct3 = 3'd0;
      bus.in_alu = 32'd0; bus.in_pc4 = 32'h0000_1004; bus.in_imm = 32'hABCD_E000;
      bus.ld_valid = 1'b0; bus.ld_data = 32'd0;
      RdAdr1 = 5'd0; RdAdr2 = 5'd0; RfRead1 = 32'd0; RfRead2 = 32'd0;
      @(negedge clk);
      chk("rst_WrEn", 32'(WrEn), 32'd0);
      chk("rst_WrAdr", 32'(WrAdr), 32'd0);
      chk("rst_WrData", WrData, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Reset asserted mid-cycle while a write is presented
      put(5'd4, 2'd0, 3'd0, 32'h0000_4444);
      tick();
      idle();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_WrEn", 32'(WrEn), 32'd0);
      chk("midrst_cnt", 32'(retire_cnt), 32'd0);
      chk("midrst_ready", 32'(bus.in_ready), 32'd1);
      tick();
      rst_n = 1'b1;
      tick();

      // Single ALU op
      put(5'd5, 2'd0, 3'd0, 32'h0000_1234);
      tick();
      idle();
      @(negedge clk);
      chk("alu_WrEn", 32'(WrEn), 32'd1);
      chk("alu_WrAdr", 32'(WrAdr), 32'd5);
      chk("alu_WrData", WrData, 32'h0000_1234);
      tick();
      @(negedge clk);
      chk("alu_cnt", 32'(retire_cnt), 32'd1);
      tick();

      // Loads with 0..3 wait cycles; a competing instruction is offered while waiting
      foreach (lv[i]) begin
         put(5'(i + 1), 2'd1, lv[i].f3, 32'h0000_0100 | 32'(lv[i].off));
         if (i == 1) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 32'hFFFF_FFFF;
         end
         tick();
         bus.ld_valid = 1'b0;
         put(5'd31, 2'd0, 3'd0, 32'hDEAD_0000);
         for (int w = 0; w < (i % 4); w++) begin
            @(negedge clk);
            chk("ld_wait_ready", 32'(bus.in_ready), 32'd0);
            tick();
         end
         bus.ld_valid = 1'b1;
         bus.ld_data  = lv[i].data;
         tick();
         idle();
         @(negedge clk);
         chk("ld_WrEn", 32'(WrEn), 32'd1);
         chk("ld_WrAdr", 32'(WrAdr), 32'(i + 1));
         chk("ld_WrData", WrData, lv[i].exp);
         tick();
      end

      // Flush while presenting a write
      put(5'd7, 2'd0, 3'd0, 32'h0000_0777);
      tick();
      cnt0 = m_cnt;
      flush = 1'b1;
      put(5'd12, 2'd0, 3'd0, 32'h0000_0C0C);
      @(negedge clk);
      chk("flfull_WrEn", 32'(WrEn), 32'd0);
      chk("flfull_ready", 32'(bus.in_ready), 32'd0);
      tick();
      flush = 1'b0;
      idle();
      @(negedge clk);
      chk("flfull_cnt", 32'(retire_cnt), 32'(cnt0));
      chk("flfull_empty", 32'(WrEn), 32'd0);

      // Flush while waiting for load data, then a stale ld_valid
      put(5'd8, 2'd1, 3'd2, 32'h0000_0200);
      tick();
      idle();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.ld_valid = 1'b1;
      bus.ld_data  = 32'h5555_AAAA;
      @(negedge clk);
      chk("flld_ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.ld_valid = 1'b0;
      @(negedge clk);
      chk("flld_WrEn", 32'(WrEn), 32'd0);
      chk("flld_cnt", 32'(retire_cnt), 32'(cnt0));
      tick();

      // Back-to-back rd=0..3 with mixed sources
      cnt0 = m_cnt;
      put(5'd0, 2'd0, 3'd0, 32'h0000_0A00);
      tick();
      @(negedge clk);
      chk("b2b_WrEn0", 32'(WrEn), 32'd0);
      put(5'd1, 2'd2, 3'd0, 32'h0000_0A01);
      tick();
      @(negedge clk);
      chk("b2b_WrEn1", 32'(WrEn), 32'd1);
      chk("b2b_pc4", WrData, 32'h0000_1004);
      put(5'd2, 2'd3, 3'd0, 32'h0000_0A02);
      tick();
      @(negedge clk);
      chk("b2b_WrEn2", 32'(WrEn), 32'd1);
      chk("b2b_imm", WrData, 32'hABCD_E000);
      put(5'd3, 2'd0, 3'd0, 32'h0000_0A03);
      tick();
      idle();
      @(negedge clk);
      chk("b2b_WrEn3", 32'(WrEn), 32'd1);
      chk("b2b_alu", WrData, 32'h0000_0A03);
      tick();
      @(negedge clk);
      chk("b2b_cnt", 32'(retire_cnt), 32'(cnt0 + CW'(4)));
      tick();

      // Same-cycle forwarding
      put(5'd9, 2'd0, 3'd0, 32'h0000_DEAD);
      tick();
      idle();
      RdAdr1 = 5'd9; RfRead1 = 32'd0;
      RdAdr2 = 5'd3; RfRead2 = 32'h0000_0077;
`ifdef WB_BYPASS_EN
      exp_r1 = 32'h0000_DEAD;
`else
      exp_r1 = 32'd0;
`endif
      @(negedge clk);
      chk("byp_Read1", Read1, exp_r1);
      chk("byp_Read2", Read2, 32'h0000_0077);
      #1 flush = 1'b1;
      #1;
      chk("byp_flush_Read1", Read1, 32'd0);
      tick();
      flush = 1'b0;
      RdAdr1 = 5'd0; RfRead1 = 32'h0000_0011;
      put(5'd0, 2'd0, 3'd0, 32'h0000_BEEF);
      tick();
      idle();
      @(negedge clk);
      chk("byp_x0_Read1", Read1, 32'h0000_0011);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
